// File: rtl/seq_div32.sv
// seq_div32: iterative radix-2 restoring unsigned divider, one quotient bit per clock,
// behind a start/busy/done handshake with registered quotient, remainder and div-by-zero flag.
module seq_div32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   p_q, p_d, shl, t;
    logic [WIDTH-1:0] sh_q, sh_d, dvs_q, dvs_d, quo_q, quo_d, rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dbz_q, dbz_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            sh_q    <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            sh_q    <= sh_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        sh_d    = sh_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        shl     = {p_q[WIDTH-1:0], sh_q[WIDTH-1]};
        t       = shl - {1'b0, dvs_q};
        if (state_q == CALC) begin
            // a set MSB on the trial difference means the divisor did not fit: restore
            p_d   = t[WIDTH] ? shl : t;
            sh_d  = {sh_q[WIDTH-2:0], ~t[WIDTH]};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                quo_d   = sh_d;
                rem_d   = p_d[WIDTH-1:0];
                dbz_d   = 1'b0;
                state_d = DONE;
            end
        end else if (start) begin
            dvs_d = divisor;
            if (divisor == '0) begin
                quo_d   = '1;
                rem_d   = dividend;
                dbz_d   = 1'b1;
                state_d = DONE;
            end else begin
                p_d     = '0;
                sh_d    = dividend;
                cnt_d   = CNT_W'(WIDTH);
                state_d = CALC;
            end
        end else begin
            state_d = IDLE;
        end
    end

    assign busy        = (state_q == CALC);
    assign done        = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_div32.sv
// tb_seq_div32: directed checks of seq_div32 results, latency, handshake and reset behaviour.
module tb_seq_div32;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;

    int total = 0;
    int bad = 0;
    logic [31:0] prev_q = '0;
    logic [31:0] prev_r = '0;

    seq_div32 #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        step();
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    // waits for done; inj >= 0 pulses a 7/7 request at that busy cycle, which must be ignored
    task automatic finish_op(input string tag, input logic [31:0] eq, input logic [31:0] er,
                             input logic edbz, input int elat, input int inj);
        int  n = 0;
        logic busy_ok = 1'b1;
        logic held_ok = 1'b1;
        while (!done && n < 100) begin
            if (!busy) busy_ok = 1'b0;
            if (quotient !== prev_q || remainder !== prev_r) held_ok = 1'b0;
            if (n == inj) begin
                start = 1'b1;
                dividend = 32'd7;
                divisor = 32'd7;
            end
            step();
            start = 1'b0;
            n++;
        end
        check({tag, ".lat"}, 64'(n), 64'(elat));
        check({tag, ".busy_calc"}, 64'(busy_ok), 64'd1);
        check({tag, ".held"}, 64'(held_ok), 64'd1);
        check({tag, ".busy_done"}, 64'(busy), 64'd0);
        check({tag, ".q"}, 64'(quotient), 64'(eq));
        check({tag, ".r"}, 64'(remainder), 64'(er));
        check({tag, ".dbz"}, 64'(div_by_zero), 64'(edbz));
        prev_q = eq;
        prev_r = er;
    endtask

    task automatic pulse_end(input string tag);
        step();
        check({tag, ".pulse"}, 64'(done), 64'd0);
        check({tag, ".idle_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] eq, input logic [31:0] er);
        launch(a, b);
        finish_op(tag, eq, er, b == 0, b == 0 ? 0 : 32, -1);
        pulse_end(tag);
    endtask

    initial begin
        step();
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.q", 64'(quotient), 64'd0);
        check("rst.r", 64'(remainder), 64'd0);
        check("rst.dbz", 64'(div_by_zero), 64'd0);
        rst_n = 1'b1;
        step();

        op("d100_7", 32'd100, 32'd7, 32'd14, 32'd2);
        op("ff_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
        op("ff_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0);
        op("d3_10", 32'd3, 32'd10, 32'd0, 32'd3);
        op("d5_0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
        op("d9_3", 32'd9, 32'd3, 32'd3, 32'd0);
        op("d0_5", 32'd0, 32'd5, 32'd0, 32'd0);
        op("msb_2p16", 32'h8000_0001, 32'h0001_0000, 32'h0000_8000, 32'd1);

        launch(32'd1000, 32'd10);
        finish_op("ign", 32'd100, 32'd0, 1'b0, 32, 10);
        launch(32'd7, 32'd7);
        finish_op("b2b", 32'd1, 32'd0, 1'b0, 32, -1);
        pulse_end("b2b");

        launch(32'h1234_5678, 32'h1234);
        for (int i = 0; i < 15; i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.busy", 64'(busy), 64'd0);
        check("arst.done", 64'(done), 64'd0);
        check("arst.q", 64'(quotient), 64'd0);
        check("arst.r", 64'(remainder), 64'd0);
        check("arst.dbz", 64'(div_by_zero), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        begin
            int seen = 0;
            for (int i = 0; i < 40; i++) begin
                if (done) seen++;
                step();
            end
            check("arst.no_done", 64'(seen), 64'd0);
        end
        prev_q = '0;
        prev_r = '0;
        op("post_rst", 32'h1234_5678, 32'h1234, 32'h0001_0004, 32'h0000_0DA8);

        for (int k = 0; k < 200; k++) begin
            logic [31:0] a, b;
            a = $urandom;
            case (k % 4)
                0: b = 32'd1;
                1: b = 32'd1 << $urandom_range(31);
                2: b = 32'hFFFF_FFFF;
                default: b = $urandom >> $urandom_range(31);
            endcase
            if (b == 0) b = 32'd3;
            launch(a, b);
            finish_op("rnd", a / b, a % b, 1'b0, 32, -1);
            check("rnd.qdr", 64'(quotient) * 64'(b) + 64'(remainder), 64'(a));
            check("rnd.r_lt_d", 64'(remainder < b), 64'd1);
            pulse_end("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
